// File: rtl/dmem_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port data memory.
// One transaction in flight; illegal addresses answer with an error pulse.
module dmem_arbiter #(
  parameter int MEM_WORDS = 1024
) (
  input  logic                         i_clock,
  input  logic                         i_reset,

  input  logic                         i_req0_valid,
  output logic                         o_req0_ready,
  input  logic                         i_req0_we,
  input  logic [31:0]                  i_req0_addr,
  input  logic [31:0]                  i_req0_wdata,
  input  logic [3:0]                   i_req0_be,
  output logic                         o_req0_rvalid,
  output logic [31:0]                  o_req0_rdata,
  output logic                         o_req0_err,

  input  logic                         i_req1_valid,
  output logic                         o_req1_ready,
  input  logic                         i_req1_we,
  input  logic [31:0]                  i_req1_addr,
  input  logic [31:0]                  i_req1_wdata,
  input  logic [3:0]                   i_req1_be,
  output logic                         o_req1_rvalid,
  output logic [31:0]                  o_req1_rdata,
  output logic                         o_req1_err,

  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [$clog2(MEM_WORDS)-1:0] o_mem_addr,
  output logic [31:0]                  o_mem_wdata,
  output logic [3:0]                   o_mem_be,
  input  logic [31:0]                  i_mem_rdata
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_t;

  state_t      state;
  logic        last_grant;
  logic        id_q;
  logic        we_q;

  logic        grant0;
  logic        grant1;
  logic        accept;
  logic        sel;
  logic        s_we;
  logic [31:0] s_addr;
  logic [31:0] s_wdata;
  logic [3:0]  s_be;
  logic        bad;
  logic        rd_ok;

  // Contention goes to whichever side did not win last time.
  always_comb begin
    grant0 = i_req0_valid & (~i_req1_valid | last_grant);
    grant1 = i_req1_valid & (~i_req0_valid | ~last_grant);
  end

  assign o_req0_ready = (state == IDLE) & ~i_reset & grant0;
  assign o_req1_ready = (state == IDLE) & ~i_reset & grant1;
  assign accept       = o_req0_ready | o_req1_ready;
  assign sel          = o_req1_ready;

  always_comb begin
    s_we    = sel ? i_req1_we    : i_req0_we;
    s_addr  = sel ? i_req1_addr  : i_req0_addr;
    s_wdata = sel ? i_req1_wdata : i_req0_wdata;
    s_be    = sel ? i_req1_be    : i_req0_be;
  end

  assign bad = (|s_addr[1:0]) | (|s_addr[31:AW+2]);

  // Read data is taken straight from the memory in the response cycle.
  assign rd_ok = (state == RESP) & ~we_q & ~i_reset;

  assign o_req0_rdata = (rd_ok & ~id_q) ? i_mem_rdata : 32'h0;
  assign o_req1_rdata = (rd_ok &  id_q) ? i_mem_rdata : 32'h0;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state         <= IDLE;
      last_grant    <= 1'b1;
      id_q          <= 1'b0;
      we_q          <= 1'b0;
      o_req0_rvalid <= 1'b0;
      o_req1_rvalid <= 1'b0;
      o_req0_err    <= 1'b0;
      o_req1_err    <= 1'b0;
      o_mem_en      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= 32'h0;
      o_mem_be      <= 4'h0;
    end else begin
      o_req0_rvalid <= 1'b0;
      o_req1_rvalid <= 1'b0;
      o_req0_err    <= 1'b0;
      o_req1_err    <= 1'b0;
      o_mem_en      <= 1'b0;
      o_mem_we      <= 1'b0;
      o_mem_addr    <= '0;
      o_mem_wdata   <= 32'h0;
      o_mem_be      <= 4'h0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= sel;
            id_q       <= sel;
            we_q       <= s_we;
            if (bad) begin
              state <= ERR;
              if (sel) begin
                o_req1_rvalid <= 1'b1;
                o_req1_err    <= 1'b1;
              end else begin
                o_req0_rvalid <= 1'b1;
                o_req0_err    <= 1'b1;
              end
            end else begin
              state       <= ACCESS;
              o_mem_en    <= 1'b1;
              o_mem_we    <= s_we;
              o_mem_addr  <= s_addr[AW+1:2];
              o_mem_wdata <= s_wdata;
              // Reads always fetch the whole word.
              o_mem_be    <= s_we ? s_be : 4'hF;
            end
          end
        end
        ACCESS: begin
          state <= RESP;
          if (id_q) o_req1_rvalid <= 1'b1;
          else      o_req0_rvalid <= 1'b1;
        end
        RESP: state <= IDLE;
        ERR:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter with a word-level reference memory
// and a behavioural memory on the memory port.
module tb_dmem_arbiter;

  localparam int MW = 1024;
  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          v0, we0, v1, we1;
  logic [31:0]   a0, d0, a1, d1;
  logic [3:0]    be0, be1;
  logic          r0, rv0, er0, r1, rv1, er1;
  logic [31:0]   rd0, rd1;
  logic          o_mem_en, o_mem_we;
  logic [AW-1:0] o_mem_addr;
  logic [31:0]   o_mem_wdata;
  logic [3:0]    o_mem_be;
  logic [31:0]   mem_rdata;

  dmem_arbiter #(.MEM_WORDS(MW)) dut (
    .i_clock(clk), .i_reset(rst),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_we(we0),
    .i_req0_addr(a0), .i_req0_wdata(d0), .i_req0_be(be0),
    .o_req0_rvalid(rv0), .o_req0_rdata(rd0), .o_req0_err(er0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_we(we1),
    .i_req1_addr(a1), .i_req1_wdata(d1), .i_req1_be(be1),
    .o_req1_rvalid(rv1), .o_req1_rdata(rd1), .o_req1_err(er1),
    .o_mem_en(o_mem_en), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_be(o_mem_be),
    .i_mem_rdata(mem_rdata)
  );

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    return (32'(i) * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Behavioural single-port memory: read data one cycle after the strobe.
  logic [31:0] emem [MW];
  bit loaded = 0;
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < MW; i++) emem[i] <= init_word(i);
      loaded <= 1;
    end else if (o_mem_en && o_mem_we) begin
      for (int b = 0; b < 4; b++)
        if (o_mem_be[b]) emem[o_mem_addr][8*b +: 8] <= o_mem_wdata[8*b +: 8];
    end
    mem_rdata <= (o_mem_en && !o_mem_we) ? emem[o_mem_addr] : $urandom;
  end

  logic [31:0] ref_mem [MW];

  task automatic set_req(input bit p, input logic v, input logic we,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [3:0] be);
    if (p) begin v1 = v; we1 = we; a1 = a; d1 = d; be1 = be; end
    else   begin v0 = v; we0 = we; a0 = a; d0 = d; be0 = be; end
  endtask

  function automatic logic [33:0] resp(bit p);
    return p ? {rv1, er1, rd1} : {rv0, er0, rd0};
  endfunction

  function automatic logic ready(bit p);
    return p ? r1 : r0;
  endfunction

  function automatic logic [105:0] all_out();
    return {r0, rv0, er0, rd0, r1, rv1, er1, rd1,
            o_mem_en, o_mem_we, o_mem_be};
  endfunction

  function automatic logic [68:0] mem_out();
    return {o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be};
  endfunction

  task automatic txn(input bit p, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [3:0] be,
                     input int exp_wait);
    bit bad;
    int n, idx;
    logic [31:0] exp_rd;
    logic [3:0] exp_be;
    bad = (addr[1:0] != 2'b00) || ((addr >> 2) >= MW);
    idx = int'(addr[AW+1:2]);
    set_req(p, 1'b1, we, addr, wdata, be);
    #1;
    n = 0;
    while (!ready(p) && n < 10) begin
      @(negedge clk); #1; n++;
    end
    vectors++;
    if (!ready(p) || (exp_wait >= 0 && n != exp_wait)) begin
      miscompares++;
      $display("FAIL accept_wait port%0d: waited %0d cycles, required %0d",
               p, n, exp_wait);
    end
    vectors++;
    if (ready(!p) !== 1'b0) begin
      miscompares++;
      $display("FAIL other_ready port%0d: got %b, required 0", !p, ready(!p));
    end
    @(negedge clk);
    set_req(p, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
    if (bad) begin
      vectors++;
      if ({resp(p), o_mem_en} !== {1'b1, 1'b1, 32'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL err_resp port%0d addr=%h: rv/err/rdata/en=%h, required %h",
                 p, addr, {resp(p), o_mem_en}, {1'b1, 1'b1, 32'h0, 1'b0});
      end
    end else begin
      exp_be = we ? be : 4'hF;
      vectors++;
      if ({mem_out(), resp(p)} !== {1'b1, we, addr[AW+1:2], wdata, exp_be, 34'h0}) begin
        miscompares++;
        $display("FAIL access port%0d addr=%h: mem=%h resp=%h, required mem=%h",
                 p, addr, mem_out(), resp(p),
                 {1'b1, we, addr[AW+1:2], wdata, exp_be});
      end
      if (we) begin
        for (int b = 0; b < 4; b++)
          if (be[b]) ref_mem[idx][8*b +: 8] = wdata[8*b +: 8];
        exp_rd = 32'h0;
      end else begin
        exp_rd = ref_mem[idx];
      end
      @(negedge clk);
      vectors++;
      if (resp(p) !== {1'b1, 1'b0, exp_rd}) begin
        miscompares++;
        $display("FAIL resp port%0d addr=%h we=%b: got %h, required %h",
                 p, addr, we, resp(p), {1'b1, 1'b0, exp_rd});
      end
      vectors++;
      if (mem_out() !== 69'h0) begin
        miscompares++;
        $display("FAIL mem_idle: got %h, required 0", mem_out());
      end
    end
    vectors++;
    if (resp(!p) !== 34'h0) begin
      miscompares++;
      $display("FAIL other_resp port%0d: got %h, required 0", !p, resp(!p));
    end
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk);
    rst = 1'b1;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic test_reset();
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b1, 32'h4, 32'h1, 4'hF);
    do_reset(2);
    vectors++;
    if (all_out() !== 106'h0 || mem_out() !== 69'h0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h / %h, required 0", all_out(), mem_out());
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_directed();
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0);
    txn(1, 1'b1, 32'h8, 32'h12345678, 4'b0011, 1);
    txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 1);
    txn(1, 1'b1, 32'hC, 32'hFFFFFFFF, 4'b0000, 1);
    txn(1, 1'b0, 32'hC, 32'h0, 4'hF, 1);
  endtask

  task automatic test_errors();
    txn(0, 1'b0, 32'h2, 32'h0, 4'hF, 1);
    txn(0, 1'b0, 32'h1000, 32'h0, 4'hF, 1);
    txn(1, 1'b1, 32'hFFFF_FFFC, 32'h55, 4'hF, 1);
    txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 1);
  endtask

  task automatic test_random();
    logic [31:0] addr;
    int mode;
    for (int i = 0; i < 60; i++) begin
      mode = $urandom_range(0, 9);
      if (mode == 0)      addr = 32'($urandom_range(0, 127)) | 32'($urandom_range(1, 3));
      else if (mode == 1) addr = {$urandom_range(1, 1023), 22'h0} | 32'($urandom_range(0, 63) << 2);
      else if (mode == 2) addr = 32'($urandom_range(1024, 4095)) << 2;
      else                addr = 32'($urandom_range(0, 31)) << 2;
      txn(1'($urandom), 1'($urandom), addr, $urandom, 4'($urandom), 1);
    end
  endtask

  task automatic test_contention();
    int acc_port[$];
    int acc_cyc[$];
    do_reset(2);
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      #1;
      vectors++;
      if (r0 && r1) begin
        miscompares++;
        $display("FAIL dual_ready cycle %0d: both ready, required at most one", c);
      end
      if (r0 || r1) begin
        acc_port.push_back(r1 ? 1 : 0);
        acc_cyc.push_back(c);
      end
      @(negedge clk);
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    if (acc_port.size() != 4) begin
      miscompares++;
      $display("FAIL accept_count: got %0d, required 4", acc_port.size());
    end
    for (int k = 0; k < 4 && k < acc_port.size(); k++) begin
      vectors++;
      if (acc_port[k] != k % 2 || acc_cyc[k] != 3 * k) begin
        miscompares++;
        $display("FAIL accept_order %0d: port %0d at cycle %0d, required port %0d at cycle %0d",
                 k, acc_port[k], acc_cyc[k], k % 2, 3 * k);
      end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset_abort();
    int n;
    int seen;
    set_req(1, 1'b1, 1'b0, 32'h20, 32'h0, 4'hF);
    #1;
    n = 0;
    while (!r1 && n < 10) begin
      @(negedge clk); #1; n++;
    end
    @(negedge clk);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    if (o_mem_en !== 1'b1) begin
      miscompares++;
      $display("FAIL abort_access: mem_en=%b, required 1", o_mem_en);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if (all_out() !== 106'h0) begin
      miscompares++;
      $display("FAIL abort_reset_out: got %h, required 0", all_out());
    end
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (rv1 || o_mem_en) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL abort_no_resp: %0d cycles with rvalid1/mem_en, required 0", seen);
    end
    set_req(0, 1'b1, 1'b0, 32'h0, 32'h0, 4'hF);
    set_req(1, 1'b1, 1'b0, 32'h4, 32'h0, 4'hF);
    #1;
    vectors++;
    if ({r0, r1} !== 2'b10) begin
      miscompares++;
      $display("FAIL abort_first_grant: ready0/1=%b, required 10", {r0, r1});
    end
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    for (int i = 0; i < MW; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_directed();
    test_errors();
    test_random();
    test_contention();
    test_reset_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
